// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: access-mode encodings, size decode, FSM states and lane-enable constants
package dmem_ctrl_pkg;
   localparam logic [2:0] MODE_B  = 3'd0;
   localparam logic [2:0] MODE_H  = 3'd1;
   localparam logic [2:0] MODE_W  = 3'd2;
   localparam logic [2:0] MODE_BU = 3'd4;
   localparam logic [2:0] MODE_HU = 3'd5;
   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;
   typedef enum logic [1:0] {IDLE, RWAIT, RESP} state_e;
   // Encodings outside the byte/half families (3, 6, 7) fall through to word.
   function automatic size_e mode_size(input logic [2:0] mode);
      return (mode == MODE_B || mode == MODE_BU) ? SZ_B :
             (mode == MODE_H || mode == MODE_HU) ? SZ_H : SZ_W;
   endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: Memory-stage request/response bundle between pipeline (master) and controller (slave)
interface dmem_ctrl_if;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_in;
   logic        dmem_write;
   logic        dmem_read;
   logic [2:0]  dmem_mode;
   logic [31:0] dmem_out;
   logic        mem_stall;
   logic        dmem_misalign;
   modport master (output dmem_addr, dmem_in, dmem_write, dmem_read, dmem_mode,
                   input  dmem_out, mem_stall, dmem_misalign);
   modport slave  (input  dmem_addr, dmem_in, dmem_write, dmem_read, dmem_mode,
                   output dmem_out, mem_stall, dmem_misalign);
endinterface

// File: rtl/dmem_extract.sv
// dmem_extract: lane select plus sign/zero extension of a loaded SRAM word
module dmem_extract
   import dmem_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  lane,
   input  logic [2:0]  mode,
   output logic [31:0] data
);
   size_e       sz;
   logic        sx;
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      sz   = mode_size(mode);
      sx   = mode == MODE_B || mode == MODE_H;
      b    = rdata[8*lane +: 8];
      h    = lane[1] ? rdata[31:16] : rdata[15:0];
      data = sz == SZ_B ? {{24{sx & b[7]}}, b} :
             sz == SZ_H ? {{16{sx & h[15]}}, h} : rdata;
   end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for a 1-cycle-latency word SRAM; DMEM_MISALIGN_TRAP_EN traps misaligned
// half/word accesses instead of forcing them to alignment.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   dmem_ctrl_if.slave            bus,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [3:0]            sram_be,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   input  logic [31:0]           sram_rdata
);
   state_e      state;
   size_e       sz;
   logic [1:0]  lane;
   logic        trap;
   logic        go;
   logic        wr;
   logic        rd;
   logic [31:0] ext;
   logic        unused_addr;
   assign unused_addr = ^bus.dmem_addr[31:ADDR_WIDTH+2];
   always_comb begin
      sz   = mode_size(bus.dmem_mode);
      lane = sz == SZ_B ? bus.dmem_addr[1:0] : sz == SZ_H ? {bus.dmem_addr[1], 1'b0} : 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
      trap = lane != bus.dmem_addr[1:0];
`else
      trap = 1'b0;
`endif
      // Reset gates the strobes so nothing reaches the SRAM while it is held.
      go                = state == IDLE && !rst;
      wr                = go && bus.dmem_write && !trap;
      rd                = go && bus.dmem_read && !bus.dmem_write && !trap;
      bus.dmem_misalign = go && trap && (bus.dmem_write || bus.dmem_read);
      bus.mem_stall     = rd || state == RWAIT;
      sram_en           = wr || rd;
      sram_we           = wr;
      sram_be           = sram_en ? (sz == SZ_B ? BE_B : sz == SZ_H ? BE_H : BE_W) << lane : 4'b0000;
      sram_addr         = bus.dmem_addr[ADDR_WIDTH+1:2];
      sram_wdata        = sz == SZ_B ? {4{bus.dmem_in[7:0]}} :
                          sz == SZ_H ? {2{bus.dmem_in[15:0]}} : bus.dmem_in;
   end
   dmem_extract u_extract (
      .rdata (sram_rdata),
      .lane  (lane),
      .mode  (bus.dmem_mode),
      .data  (ext)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         bus.dmem_out <= '0;
      end else begin
         state <= state == IDLE ? (rd ? RWAIT : IDLE) : state == RWAIT ? RESP : IDLE;
         if (state == RWAIT) bus.dmem_out <= ext;
      end
   end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: randomized self-checking bench with a byte-array reference memory
module tb_dmem_ctrl;
   import dmem_ctrl_pkg::*;
   localparam int AW = 10;
   logic          clk = 1'b0;
   logic          rst;
   logic          sram_en;
   logic          sram_we;
   logic [3:0]    sram_be;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic [31:0]   sram_rdata;
   logic [31:0]   sram [1<<AW] = '{default: 32'h0};
   logic [7:0]    ref_mem [4096] = '{default: 8'h0};
   int            checks = 0;
   int            errors = 0;
   int            reads = 0;
   logic [31:0]   last_out = 32'h0;

   always #5 clk = ~clk;

   dmem_ctrl_if bus ();

   dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sram_en    (sram_en),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always @(posedge clk) begin
      if (sram_en && !sram_we) begin
         sram_rdata <= sram[sram_addr];
         reads      <= reads + 1;
      end
      if (sram_en && sram_we)
         for (int i = 0; i < 4; i++)
            if (sram_be[i]) sram[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
   end

   function automatic int sz_of(input logic [2:0] m);
      return (m == 3'd0 || m == 3'd4) ? 1 : (m == 3'd1 || m == 3'd5) ? 2 : 4;
   endfunction

   function automatic int base_of(input logic [31:0] a, input logic [2:0] m);
      int b = a[11:0];
      return b / sz_of(m) * sz_of(m);
   endfunction

   function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] m);
      int s = sz_of(m);
      int b = base_of(a, m);
      logic [31:0] v = 32'h0;
      for (int i = 0; i < s; i++) v = v | (32'(ref_mem[b+i]) << (8*i));
      if (s < 4 && (m == 3'd0 || m == 3'd1) && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8*s));
      return v;
   endfunction

   function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] m);
      logic [3:0] be = 4'b0;
      for (int i = 0; i < sz_of(m); i++) be[(base_of(a, m) + i) % 4] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] m);
      return sz_of(m) == 1 ? {4{d[7:0]}} : sz_of(m) == 2 ? {2{d[15:0]}} : d;
   endfunction

   function automatic logic [AW-1:0] exp_sa(input logic [31:0] a, input logic [2:0] m);
      return AW'(base_of(a, m) / 4);
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
      for (int i = 0; i < sz_of(m); i++) ref_mem[base_of(a, m) + i] = d[8*i +: 8];
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m,
                              input logic rd_too, output logic [3:0] st, output logic [3:0] be,
                              output logic [31:0] wd, output logic [AW-1:0] sa);
      @(negedge clk);
      bus.dmem_addr  = a;
      bus.dmem_in    = d;
      bus.dmem_mode  = m;
      bus.dmem_write = 1'b1;
      bus.dmem_read  = rd_too;
      #1;
      st = {sram_en, sram_we, bus.mem_stall, bus.dmem_misalign};
      be = sram_be;
      wd = sram_wdata;
      sa = sram_addr;
      @(posedge clk);
      #1;
      bus.dmem_write = 1'b0;
      bus.dmem_read  = 1'b0;
   endtask

   task automatic drive_load(input logic [31:0] a, input logic [2:0] m, output logic [11:0] sts,
                             output logic [31:0] q, output int n);
      int r0;
      @(negedge clk);
      bus.dmem_addr = a;
      bus.dmem_mode = m;
      bus.dmem_read = 1'b1;
      r0 = reads;
      #1 sts[11:8] = {sram_en, sram_we, bus.mem_stall, bus.dmem_misalign};
      @(posedge clk);
      #1 sts[7:4] = {sram_en, sram_we, bus.mem_stall, bus.dmem_misalign};
      @(posedge clk);
      #1 sts[3:0] = {sram_en, sram_we, bus.mem_stall, bus.dmem_misalign};
      q = bus.dmem_out;
      @(posedge clk);
      #1 bus.dmem_read = 1'b0;
      n = reads - r0;
   endtask

   task automatic test_reset();
      rst            = 1'b1;
      bus.dmem_addr  = 32'h0;
      bus.dmem_in    = 32'h0;
      bus.dmem_mode  = 3'd0;
      bus.dmem_write = 1'b0;
      bus.dmem_read  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({sram_en, sram_we, bus.mem_stall, bus.dmem_misalign, bus.dmem_out} !== 36'h0) begin
         errors++;
         $display("FAIL reset en/we/stall/mis/out got %b/%b/%b/%b/%h want all zero",
                  sram_en, sram_we, bus.mem_stall, bus.dmem_misalign, bus.dmem_out);
      end
      rst = 1'b0;
   endtask

   task automatic test_word();
      logic [3:0] st, be; logic [31:0] wd, q; logic [AW-1:0] sa; logic [11:0] sts; int n;
      drive_store(32'h10, 32'hDEAD_BEEF, MODE_W, 1'b0, st, be, wd, sa);
      ref_store(32'h10, 32'hDEAD_BEEF, MODE_W);
      checks += 2;
      if ({st, be} !== 8'b1100_1111) begin errors++; $display("FAIL sw_strobes st/be got %b/%b want 1100/1111", st, be); end
      if ({wd, sa} !== {32'hDEAD_BEEF, AW'(4)}) begin errors++; $display("FAIL sw_data wdata/addr got %h/%h want deadbeef/004", wd, sa); end
      drive_load(32'h10, MODE_W, sts, q, n);
      checks += 3;
      if (sts !== 12'b1010_0010_0000) begin errors++; $display("FAIL lw_stall states got %b want 101000100000", sts); end
      if (q !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", q); end
      if (n !== 1) begin errors++; $display("FAIL lw_reads got %0d want 1", n); end
      last_out = q;
   endtask

   task automatic test_byte();
      logic [3:0] st, be; logic [31:0] wd, q; logic [AW-1:0] sa; logic [11:0] sts; int n;
      drive_store(32'h13, 32'h0000_0080, MODE_B, 1'b0, st, be, wd, sa);
      ref_store(32'h13, 32'h80, MODE_B);
      checks += 2;
      if ({st, be} !== 8'b1100_1000) begin errors++; $display("FAIL sb_strobes st/be got %b/%b want 1100/1000", st, be); end
      if (wd !== 32'h8080_8080) begin errors++; $display("FAIL sb_wdata got %h want 80808080", wd); end
      drive_load(32'h13, MODE_B, sts, q, n);
      checks++;
      if (q !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", q); end
      drive_load(32'h13, MODE_BU, sts, q, n);
      checks++;
      if (q !== 32'h0000_0080) begin errors++; $display("FAIL lbu_data got %h want 00000080", q); end
      last_out = q;
   endtask

   task automatic test_half();
      logic [3:0] st, be; logic [31:0] wd, q; logic [AW-1:0] sa; logic [11:0] sts; int n;
      drive_store(32'h22, 32'h0000_8001, MODE_H, 1'b0, st, be, wd, sa);
      ref_store(32'h22, 32'h8001, MODE_H);
      checks += 2;
      if ({st, be} !== 8'b1100_1100) begin errors++; $display("FAIL sh_strobes st/be got %b/%b want 1100/1100", st, be); end
      if (wd !== 32'h8001_8001) begin errors++; $display("FAIL sh_wdata got %h want 80018001", wd); end
      drive_load(32'h22, MODE_H, sts, q, n);
      checks++;
      if (q !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_data got %h want ffff8001", q); end
      drive_load(32'h22, MODE_HU, sts, q, n);
      checks++;
      if (q !== 32'h0000_8001) begin errors++; $display("FAIL lhu_data got %h want 00008001", q); end
      last_out = q;
   endtask

   task automatic test_simultaneous();
      logic [3:0] st, be; logic [31:0] wd, q, d; logic [AW-1:0] sa; logic [11:0] sts; int n, r0;
      d  = $urandom;
      r0 = reads;
      drive_store(32'h30, d, MODE_W, 1'b1, st, be, wd, sa);
      ref_store(32'h30, d, MODE_W);
      @(negedge clk);
      checks += 2;
      if ({st, be} !== 8'b1100_1111) begin errors++; $display("FAIL rw_strobes st/be got %b/%b want 1100/1111", st, be); end
      if (reads - r0 !== 0 || bus.mem_stall !== 1'b0) begin
         errors++; $display("FAIL rw_noread reads/stall got %0d/%b want 0/0", reads - r0, bus.mem_stall);
      end
      drive_load(32'h30, MODE_W, sts, q, n);
      checks++;
      if (q !== exp_load(32'h30, MODE_W)) begin errors++; $display("FAIL rw_readback got %h want %h", q, exp_load(32'h30, MODE_W)); end
      last_out = q;
   endtask

   task automatic test_back_to_back();
      logic [11:0] s1, s2; logic [31:0] q1, q2; int n1, n2;
      drive_load(32'h10, MODE_W, s1, q1, n1);
      drive_load(32'h14, MODE_W, s2, q2, n2);
      checks += 3;
      if ({s1, s2} !== {2{12'b1010_0010_0000}}) begin errors++; $display("FAIL b2b_stall got %b/%b want 101000100000 each", s1, s2); end
      if ({q1, q2} !== {exp_load(32'h10, MODE_W), exp_load(32'h14, MODE_W)}) begin
         errors++; $display("FAIL b2b_data got %h/%h want %h/%h", q1, q2, exp_load(32'h10, MODE_W), exp_load(32'h14, MODE_W));
      end
      if (n1 + n2 !== 2) begin errors++; $display("FAIL b2b_reads got %0d want 2", n1 + n2); end
      last_out = q2;
   endtask

   task automatic test_reset_mid_read();
      int r0;
      @(negedge clk);
      bus.dmem_addr = 32'h10;
      bus.dmem_mode = MODE_W;
      bus.dmem_read = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.mem_stall !== 1'b1) begin errors++; $display("FAIL rwait_stall got %b want 1", bus.mem_stall); end
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.dmem_out, bus.mem_stall, sram_en} !== 34'h0) begin
         errors++; $display("FAIL rst_mid out/stall/en got %h/%b/%b want 0/0/0", bus.dmem_out, bus.mem_stall, sram_en);
      end
      @(negedge clk);
      bus.dmem_read = 1'b0;
      rst           = 1'b0;
      r0            = reads;
      last_out      = 32'h0;
      repeat (4) @(negedge clk);
      checks++;
      if (reads - r0 !== 0 || bus.dmem_out !== 32'h0) begin
         errors++; $display("FAIL rst_release reads/out got %0d/%h want 0/0", reads - r0, bus.dmem_out);
      end
   endtask

   task automatic test_misalign();
      logic [11:0] sts; logic [31:0] q; int n;
`ifdef DMEM_MISALIGN_TRAP_EN
      logic [3:0] st, be; logic [31:0] wd; logic [AW-1:0] sa;
      @(negedge clk);
      bus.dmem_addr = 32'h11;
      bus.dmem_mode = MODE_W;
      bus.dmem_read = 1'b1;
      #1;
      checks++;
      if ({bus.dmem_misalign, sram_en, bus.mem_stall} !== 3'b100) begin
         errors++; $display("FAIL mis_lw mis/en/stall got %b/%b/%b want 1/0/0", bus.dmem_misalign, sram_en, bus.mem_stall);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({bus.mem_stall, bus.dmem_out} !== {1'b0, last_out}) begin
         errors++; $display("FAIL mis_hold stall/out got %b/%h want 0/%h", bus.mem_stall, bus.dmem_out, last_out);
      end
      bus.dmem_read = 1'b0;
      drive_store(32'h23, 32'h1234, MODE_H, 1'b0, st, be, wd, sa);
      checks++;
      if ({st, be} !== 8'b0001_0000) begin errors++; $display("FAIL mis_sh st/be got %b/%b want 0001/0000", st, be); end
      drive_load(32'h22, MODE_HU, sts, q, n);
      checks++;
      if (q !== exp_load(32'h22, MODE_HU)) begin errors++; $display("FAIL mis_sh_mem got %h want %h", q, exp_load(32'h22, MODE_HU)); end
`else
      drive_load(32'h11, MODE_W, sts, q, n);
      checks += 2;
      if (sts !== 12'b1010_0010_0000) begin errors++; $display("FAIL mis_lw_stall got %b want 101000100000", sts); end
      if (q !== exp_load(32'h10, MODE_W)) begin errors++; $display("FAIL mis_lw_data got %h want %h", q, exp_load(32'h10, MODE_W)); end
`endif
      last_out = q;
   endtask

   task automatic test_random();
      logic [3:0] st, be; logic [31:0] wd, q, a, d; logic [AW-1:0] sa; logic [11:0] sts; int n; logic [2:0] m;
      for (int k = 0; k < 300; k++) begin
         a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         m = 3'($urandom_range(0, 7));
`ifdef DMEM_MISALIGN_TRAP_EN
         a = a & ~32'(sz_of(m) - 1);
`endif
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            drive_store(a, d, m, 1'($urandom_range(0, 1)), st, be, wd, sa);
            ref_store(a, d, m);
            checks += 2;
            if ({st, be} !== {4'b1100, exp_be(a, m)}) begin
               errors++; $display("FAIL rnd_store a=%h m=%0d st/be got %b/%b want 1100/%b", a, m, st, be, exp_be(a, m));
            end
            if ({sa, wd} !== {exp_sa(a, m), exp_wdata(d, m)}) begin
               errors++; $display("FAIL rnd_store_data a=%h m=%0d addr/wdata got %h/%h want %h/%h", a, m, sa, wd, exp_sa(a, m), exp_wdata(d, m));
            end
         end else begin
            drive_load(a, m, sts, q, n);
            checks += 2;
            if (sts !== 12'b1010_0010_0000 || n !== 1) begin
               errors++; $display("FAIL rnd_load_seq a=%h m=%0d states/reads got %b/%0d want 101000100000/1", a, m, sts, n);
            end
            if (q !== exp_load(a, m)) begin errors++; $display("FAIL rnd_load a=%h m=%0d got %h want %h", a, m, q, exp_load(a, m)); end
            last_out = exp_load(a, m);
         end
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            #1;
            checks++;
            if ({sram_en, sram_we, bus.mem_stall, bus.dmem_out} !== {3'b000, last_out}) begin
               errors++; $display("FAIL rnd_idle en/we/stall/out got %b%b%b/%h want 000/%h", sram_en, sram_we, bus.mem_stall, bus.dmem_out, last_out);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_byte();
      test_half();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_read();
      test_misalign();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
